// File: rtl/ram_8x72_bist.sv
// March C- built-in self-test initiator for the 8x72 DFF RAM.
// Drives the RAM write/read port and reports pass/fail with the first failing address, element and bits.
module ram_8x72_bist #(
  parameter int DATA_W     = 72,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_wr_n,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_add,
  output logic [2:0]        fail_step,
  output logic [DATA_W-1:0] fail_bits
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        RD_LAST = 2'(RD_LATENCY);
  localparam logic [2:0]        STEP_LAST = 3'd5;

  state_e              state_q;
  logic [2:0]          step_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          rd_cnt_q;
  logic                wr_n_q;
  logic [ADDR_W-1:0]   add_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                fail_q;
  logic [ADDR_W-1:0]   fail_add_q;
  logic [2:0]          fail_step_q;
  logic [DATA_W-1:0]   fail_bits_q;

  logic                elem_end_d;
  logic [2:0]          step_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   miss_d;
  logic                rd_done_d;

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic is_down(input logic [2:0] s);
    return (s == 3'd3) || (s == 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] wr_pat(input logic [2:0] s);
    return ((s == 3'd1) || (s == 3'd3)) ? '1 : '0;
  endfunction

  function automatic logic [DATA_W-1:0] rd_pat(input logic [2:0] s);
    return ((s == 3'd2) || (s == 3'd4)) ? '1 : '0;
  endfunction

  always_comb begin
    elem_end_d = is_down(step_q) ? (addr_q == '0) : (addr_q == LAST_A);
    step_d     = elem_end_d ? step_q + 3'd1 : step_q;
    addr_d     = '0;
    if (!elem_end_d) begin
      addr_d = is_down(step_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end else begin
      addr_d = is_down(step_d) ? LAST_A : '0;
    end
    miss_d    = mem_rdata ^ rd_pat(step_q);
    rd_done_d = (rd_cnt_q == RD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      addr_q      <= '0;
      rd_cnt_q    <= '0;
      wr_n_q      <= 1'b1;
      add_q       <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_add_q  <= '0;
      fail_step_q <= '0;
      fail_bits_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_add_q  <= '0;
            fail_step_q <= '0;
            fail_bits_q <= '0;
            step_q      <= '0;
            addr_q      <= '0;
            rd_cnt_q    <= '0;
            wr_n_q      <= 1'b0;
            add_q       <= '0;
            wdata_q     <= wr_pat(3'd0);
            state_q     <= S_WRITE;
          end
        end
        // Every write closes the current address of its element.
        S_WRITE: begin
          step_q   <= step_d;
          addr_q   <= addr_d;
          add_q    <= addr_d;
          rd_cnt_q <= '0;
          if (step_d == 3'd0) begin
            wr_n_q  <= 1'b0;
            wdata_q <= wr_pat(3'd0);
            state_q <= S_WRITE;
          end else begin
            wr_n_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (!rd_done_d) begin
            rd_cnt_q <= rd_cnt_q + 2'd1;
          end else if (miss_d != '0) begin
            fail_q      <= 1'b1;
            fail_add_q  <= addr_q;
            fail_step_q <= step_q;
            fail_bits_q <= miss_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else if (step_q == STEP_LAST) begin
            if (elem_end_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q   <= addr_d;
              add_q    <= addr_d;
              rd_cnt_q <= '0;
            end
          end else begin
            wr_n_q  <= 1'b0;
            wdata_q <= wr_pat(step_q);
            state_q <= S_WRITE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          wdata_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_wr_n  = wr_n_q;
  assign mem_add   = add_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_add  = fail_add_q;
  assign fail_step = fail_step_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_ram_8x72_bist.sv
// Bench for ram_8x72_bist: three builds (read latency 1, 0, 2) each beside a RAM model;
// the latency-1 RAM can carry a stuck-at or coupling fault.
module tb_ram_8x72_bist;
  localparam int DW    = 72;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst, start, clr_mem;
  logic [1:0] fault;
  logic [2:0] wr_n, busy, done, pass, fail;
  logic [AW-1:0] add   [3];
  logic [DW-1:0] wdata [3];
  logic [DW-1:0] rdata [3];
  logic [AW-1:0] fadd  [3];
  logic [2:0]    fstep [3];
  logic [DW-1:0] fbits [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 2;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_c, p1, p2;

    ram_8x72_bist #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_wr_n(wr_n[g]), .mem_add(add[g]), .mem_wdata(wdata[g]), .mem_rdata(rdata[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .fail(fail[g]),
      .fail_add(fadd[g]), .fail_step(fstep[g]), .fail_bits(fbits[g]));

    // Falling write of bit 0 at address 6 inverts bit 0 of address 2 when fault==2.
    always @(posedge clk) begin
      if (clr_mem) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!wr_n[g]) begin
        mem[add[g]] <= wdata[g];
        if (g == 0 && fault == 2'd2 && add[g] == 3'd6 && mem[6][0] && !wdata[g][0])
          mem[2][0] <= ~mem[2][0];
      end
    end

    always_comb begin
      rd_c = mem[add[g]];
      if (g == 0 && fault == 2'd1 && add[g] == 3'd5) rd_c[37] = 1'b0;
    end

    always @(posedge clk) begin
      p1 <= rd_c;
      p2 <= p1;
    end

    assign rdata[g] = (LAT == 0) ? rd_c : (LAT == 1) ? p1 : p2;
  end

  typedef struct {
    bit            e_pass;
    bit            e_fail;
    logic [AW-1:0] e_add;
    logic [2:0]    e_step;
    logic [DW-1:0] e_bits;
    int            e_blen;
    int            e_wr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_pass   = 0;
  int blen [3];
  int wrc  [3];
  bit seen [3];
  bit ob_pass [3];
  bit ob_fail [3];
  logic [AW-1:0] ob_add  [3];
  logic [2:0]    ob_step [3];
  logic [DW-1:0] ob_bits [3];

  task automatic run(input int pulse_at);
    for (int g = 0; g < 3; g++) begin
      blen[g] = 0; wrc[g] = 0; seen[g] = 1'b0;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      for (int g = 0; g < 3; g++) begin
        if (!seen[g]) begin
          if (busy[g]) blen[g]++;
          if (!wr_n[g]) wrc[g]++;
          if (done[g]) begin
            seen[g] = 1'b1; ob_pass[g] = pass[g]; ob_fail[g] = fail[g];
            ob_add[g] = fadd[g]; ob_step[g] = fstep[g]; ob_bits[g] = fbits[g];
          end
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
      start = (cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic clear_mem(input logic [1:0] f);
    fault = f;
    @(negedge clk); clr_mem = 1'b1;
    @(negedge clk); clr_mem = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clr_mem = 1'b1; fault = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_n !== 3'b111) $display("FAIL reset_wr_n: got %b want 111", wr_n); else n_pass++;
    n_checks++; if ({busy, done, pass, fail} !== 12'd0) $display("FAIL reset_flags: got %h want 000", {busy, done, pass, fail}); else n_pass++;
    n_checks++; if (add[0] !== 3'd0 || wdata[0] !== '0) $display("FAIL reset_bus: got add=%0d wdata=%h want 0", add[0], wdata[0]); else n_pass++;
    n_checks++; if (fadd[0] !== 3'd0 || fstep[0] !== 3'd0 || fbits[0] !== '0) $display("FAIL reset_fail_info: got %0d %0d %h want 0", fadd[0], fstep[0], fbits[0]); else n_pass++;
    rst = 1'b0; clr_mem = 1'b0;
  endtask

  task automatic test_good();
    sb.push_back('{1'b1, 1'b0, 3'd0, 3'd0, 72'd0, 120, 40});
    run(0);
    e = sb.pop_front();
    n_checks++; if (!seen[0]) $display("FAIL good_done: got no done pulse want done within %0d", LIMIT); else n_pass++;
    n_checks++; if (blen[0] != e.e_blen) $display("FAIL good_busy_len: got %0d want %0d", blen[0], e.e_blen); else n_pass++;
    n_checks++; if (wrc[0] != e.e_wr) $display("FAIL good_writes: got %0d want %0d", wrc[0], e.e_wr); else n_pass++;
    n_checks++; if (ob_pass[0] !== e.e_pass || ob_fail[0] !== e.e_fail) $display("FAIL good_verdict: got pass=%0d fail=%0d want %0d %0d", ob_pass[0], ob_fail[0], e.e_pass, e.e_fail); else n_pass++;
    n_checks++; if (ob_bits[0] !== e.e_bits) $display("FAIL good_bits: got %h want %h", ob_bits[0], e.e_bits); else n_pass++;
    @(negedge clk);
    n_checks++; if (done[0] !== 1'b0 || pass[0] !== 1'b1 || busy[0] !== 1'b0) $display("FAIL good_hold: got done=%0d pass=%0d busy=%0d want 0 1 0", done[0], pass[0], busy[0]); else n_pass++;
  endtask

  task automatic test_latency();
    run(0);
    n_checks++; if (!seen[1] || blen[1] != 80) $display("FAIL lat0_busy_len: got seen=%0d len=%0d want 80", seen[1], blen[1]); else n_pass++;
    n_checks++; if (!seen[2] || blen[2] != 160) $display("FAIL lat2_busy_len: got seen=%0d len=%0d want 160", seen[2], blen[2]); else n_pass++;
    n_checks++; if (ob_pass[1] !== 1'b1 || ob_fail[1] !== 1'b0) $display("FAIL lat0_verdict: got pass=%0d fail=%0d want 1 0", ob_pass[1], ob_fail[1]); else n_pass++;
    n_checks++; if (ob_pass[2] !== 1'b1 || ob_fail[2] !== 1'b0) $display("FAIL lat2_verdict: got pass=%0d fail=%0d want 1 0", ob_pass[2], ob_fail[2]); else n_pass++;
    n_checks++; if (wrc[1] != 40 || wrc[2] != 40) $display("FAIL lat_writes: got %0d %0d want 40 40", wrc[1], wrc[2]); else n_pass++;
  endtask

  task automatic test_start_ignored();
    sb.push_back('{1'b1, 1'b0, 3'd0, 3'd0, 72'd0, 120, 40});
    run(40);
    e = sb.pop_front();
    n_checks++; if (!seen[0] || blen[0] != e.e_blen) $display("FAIL midstart_busy_len: got seen=%0d len=%0d want %0d", seen[0], blen[0], e.e_blen); else n_pass++;
    n_checks++; if (ob_pass[0] !== e.e_pass || wrc[0] != e.e_wr) $display("FAIL midstart_verdict: got pass=%0d writes=%0d want %0d %0d", ob_pass[0], wrc[0], e.e_pass, e.e_wr); else n_pass++;
  endtask

  task automatic test_stuck_at();
    clear_mem(2'd1);
    sb.push_back('{1'b0, 1'b1, 3'd5, 3'd2, 72'd1 << 37, 49, 21});
    run(0);
    e = sb.pop_front();
    n_checks++; if (!seen[0]) $display("FAIL stuck_done: got no done pulse want done within %0d", LIMIT); else n_pass++;
    n_checks++; if (ob_pass[0] !== e.e_pass || ob_fail[0] !== e.e_fail) $display("FAIL stuck_verdict: got pass=%0d fail=%0d want %0d %0d", ob_pass[0], ob_fail[0], e.e_pass, e.e_fail); else n_pass++;
    n_checks++; if (ob_add[0] !== e.e_add || ob_step[0] !== e.e_step) $display("FAIL stuck_where: got add=%0d step=%0d want %0d %0d", ob_add[0], ob_step[0], e.e_add, e.e_step); else n_pass++;
    n_checks++; if (ob_bits[0] !== e.e_bits) $display("FAIL stuck_bits: got %h want %h", ob_bits[0], e.e_bits); else n_pass++;
    n_checks++; if (blen[0] != e.e_blen || wrc[0] != e.e_wr) $display("FAIL stuck_abort: got len=%0d writes=%0d want %0d %0d", blen[0], wrc[0], e.e_blen, e.e_wr); else n_pass++;
    n_checks++; if (wr_n[0] !== 1'b1 || fail[0] !== 1'b1 || pass[0] !== 1'b0) $display("FAIL stuck_hold: got wr_n=%0d fail=%0d pass=%0d want 1 1 0", wr_n[0], fail[0], pass[0]); else n_pass++;
  endtask

  task automatic test_coupling();
    clear_mem(2'd2);
    sb.push_back('{1'b0, 1'b1, 3'd2, 3'd3, 72'd1, 73, 29});
    run(0);
    e = sb.pop_front();
    n_checks++; if (!seen[0] || ob_fail[0] !== e.e_fail || ob_pass[0] !== e.e_pass) $display("FAIL coup_verdict: got seen=%0d pass=%0d fail=%0d want 1 %0d %0d", seen[0], ob_pass[0], ob_fail[0], e.e_pass, e.e_fail); else n_pass++;
    n_checks++; if (ob_add[0] !== e.e_add || ob_step[0] !== e.e_step) $display("FAIL coup_where: got add=%0d step=%0d want %0d %0d", ob_add[0], ob_step[0], e.e_add, e.e_step); else n_pass++;
    n_checks++; if (ob_bits[0] !== e.e_bits) $display("FAIL coup_bits: got %h want %h", ob_bits[0], e.e_bits); else n_pass++;
    n_checks++; if (blen[0] != e.e_blen || wrc[0] != e.e_wr) $display("FAIL coup_abort: got len=%0d writes=%0d want %0d %0d", blen[0], wrc[0], e.e_blen, e.e_wr); else n_pass++;
    clear_mem(2'd0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    n_checks++; if (busy[0] !== 1'b1) $display("FAIL midrst_running: got busy=%0d want 1", busy[0]); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 3'b000 || wr_n !== 3'b111) $display("FAIL midrst_abort: got busy=%b wr_n=%b want 000 111", busy, wr_n); else n_pass++;
    n_checks++; if (pass[0] !== 1'b0 || fail[0] !== 1'b0 || done[0] !== 1'b0) $display("FAIL midrst_flags: got pass=%0d fail=%0d done=%0d want 0 0 0", pass[0], fail[0], done[0]); else n_pass++;
    rst = 1'b0;
    sb.push_back('{1'b1, 1'b0, 3'd0, 3'd0, 72'd0, 120, 40});
    run(0);
    e = sb.pop_front();
    n_checks++; if (!seen[0] || blen[0] != e.e_blen || ob_pass[0] !== e.e_pass) $display("FAIL midrst_rerun: got seen=%0d len=%0d pass=%0d want 1 %0d %0d", seen[0], blen[0], ob_pass[0], e.e_blen, e.e_pass); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_latency();
    test_start_ignored();
    test_stuck_at();
    test_coupling();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
